// File: rtl/mem_wb_if.sv
// MEM/WB bus: instruction fields from MEM, stall/flush control,
// register-file write port, forwarding, bypass and retire count.
interface mem_wb_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
);
  logic                      valid_in;
  logic                      RegWrite_in;
  logic                      MemToReg_in;
  logic [REG_ADDR_WIDTH-1:0] DestReg_in;
  logic [DATA_WIDTH-1:0]     ALU_result_in;
  logic [DATA_WIDTH-1:0]     MemRead_data;
  logic                      stall;
  logic                      flush;
  logic                      reg_we;
  logic [REG_ADDR_WIDTH-1:0] reg_waddr;
  logic [DATA_WIDTH-1:0]     reg_wdata;
  logic                      fwd_valid;
  logic [REG_ADDR_WIDTH-1:0] fwd_reg;
  logic [DATA_WIDTH-1:0]     fwd_data;
  logic                      last_we;
  logic [REG_ADDR_WIDTH-1:0] last_waddr;
  logic [DATA_WIDTH-1:0]     last_wdata;
  logic [CNT_WIDTH-1:0]      retired_count;

  modport master (
    output valid_in, RegWrite_in, MemToReg_in,
    output DestReg_in, ALU_result_in, MemRead_data,
    output stall, flush,
    input  reg_we, reg_waddr, reg_wdata,
    input  fwd_valid, fwd_reg, fwd_data,
    input  last_we, last_waddr, last_wdata,
    input  retired_count
  );

  modport slave (
    input  valid_in, RegWrite_in, MemToReg_in,
    input  DestReg_in, ALU_result_in, MemRead_data,
    input  stall, flush,
    output reg_we, reg_waddr, reg_wdata,
    output fwd_valid, fwd_reg, fwd_data,
    output last_we, last_waddr, last_wdata,
    output retired_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage: one register-file
// write per instruction, WB forwarding, last-write bypass, retire count.
module mem_wb_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input logic     clk,
  input logic     rst,
  mem_wb_if.slave bus
);
  logic                      v_q, v_d;
  logic                      rw_q, rw_d;
  logic                      done_q, done_d;
  logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      last_we_q;
  logic [REG_ADDR_WIDTH-1:0] last_waddr_q;
  logic [DATA_WIDTH-1:0]     last_wdata_q;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  logic                      we;
  logic                      retire;
  logic [REG_ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0]     wdata;

  assign we     = v_q & rw_q & ~done_q & (dest_q != '0);
  assign retire = v_q & ~done_q;
  assign waddr  = we ? dest_q  : '0;
  assign wdata  = we ? wdata_q : '0;

  always_comb begin
    v_d     = bus.valid_in;
    rw_d    = bus.RegWrite_in;
    dest_d  = bus.DestReg_in;
    wdata_d = bus.MemToReg_in ? bus.MemRead_data
                              : bus.ALU_result_in;
    done_d  = 1'b0;
    cnt_d   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, retire};
    if (bus.flush) begin
      v_d     = 1'b0;
      rw_d    = 1'b0;
      dest_d  = '0;
      wdata_d = '0;
    end else if (bus.stall) begin
      v_d     = v_q;
      rw_d    = rw_q;
      dest_d  = dest_q;
      wdata_d = wdata_q;
      // any held instruction, writing or not, is finished after one cycle
      done_d  = done_q | v_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q          <= 1'b0;
      rw_q         <= 1'b0;
      done_q       <= 1'b0;
      dest_q       <= '0;
      wdata_q      <= '0;
      last_we_q    <= 1'b0;
      last_waddr_q <= '0;
      last_wdata_q <= '0;
      cnt_q        <= '0;
    end else begin
      v_q          <= v_d;
      rw_q         <= rw_d;
      done_q       <= done_d;
      dest_q       <= dest_d;
      wdata_q      <= wdata_d;
      last_we_q    <= we;
      last_waddr_q <= waddr;
      last_wdata_q <= wdata;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.reg_we        = we;
  assign bus.reg_waddr     = waddr;
  assign bus.reg_wdata     = wdata;
  assign bus.fwd_valid     = we;
  assign bus.fwd_reg       = waddr;
  assign bus.fwd_data      = wdata;
  assign bus.last_we       = last_we_q;
  assign bus.last_waddr    = last_waddr_q;
  assign bus.last_wdata    = last_wdata_q;
  assign bus.retired_count = cnt_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, wrap test on a
// 4-bit counter instance, then random traffic against a reference model.
module tb_mem_wb_stage;
  typedef struct {
    logic        rst, v, rw, m2r, stall, flush;
    logic [4:0]  dest;
    logic [31:0] alu, ld;
  } in_t;

  typedef struct {
    in_t         i;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        lwe;
    logic [4:0]  lwa;
    logic [31:0] lwd;
    logic [31:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) b32();
  mem_wb_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4))  b4();

  mem_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(b32)
  );
  mem_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .bus(b4)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the instruction sitting in WB and how many cycles
  // it has spent there; it writes/retires only in its first cycle.
  bit          m_v, m_rw;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  int          m_age;
  bit          m_lwe;
  logic [4:0]  m_lwa;
  logic [31:0] m_lwd;
  int unsigned m_cnt;

  function automatic in_t mi(bit r, bit v, bit rw, bit m2r, bit st, bit fl,
                             logic [4:0] d, logic [31:0] a, logic [31:0] l);
    in_t x;
    x.rst = r; x.v = v; x.rw = rw; x.m2r = m2r;
    x.stall = st; x.flush = fl; x.dest = d; x.alu = a; x.ld = l;
    return x;
  endfunction

  function automatic vec_t mv(in_t x, bit we, logic [4:0] wa, logic [31:0] wd,
                              bit lwe, logic [4:0] lwa, logic [31:0] lwd,
                              logic [31:0] cnt);
    vec_t t;
    t.i = x; t.we = we; t.wa = wa; t.wd = wd;
    t.lwe = lwe; t.lwa = lwa; t.lwd = lwd; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", n, a, e, $time);
    end
  endtask

  task automatic apply(input in_t x);
    rst = x.rst;
    b32.valid_in = x.v;    b4.valid_in = x.v;
    b32.RegWrite_in = x.rw; b4.RegWrite_in = x.rw;
    b32.MemToReg_in = x.m2r; b4.MemToReg_in = x.m2r;
    b32.DestReg_in = x.dest; b4.DestReg_in = x.dest;
    b32.ALU_result_in = x.alu; b4.ALU_result_in = x.alu;
    b32.MemRead_data = x.ld; b4.MemRead_data = x.ld;
    b32.stall = x.stall;   b4.stall = x.stall;
    b32.flush = x.flush;   b4.flush = x.flush;
  endtask

  function automatic bit m_we();
    return m_v && m_rw && (m_age == 0) && (m_dest != 5'd0);
  endfunction

  task automatic model_edge(input in_t x);
    bit w;
    w = m_we();
    if (x.rst) begin
      m_v = 0; m_rw = 0; m_dest = '0; m_data = '0; m_age = 0;
      m_lwe = 0; m_lwa = '0; m_lwd = '0; m_cnt = 0;
    end else begin
      m_lwe = w;
      m_lwa = w ? m_dest : 5'd0;
      m_lwd = w ? m_data : 32'd0;
      if (m_v && m_age == 0) m_cnt = m_cnt + 1;
      if (x.flush) begin
        m_v = 0; m_rw = 0; m_dest = '0; m_data = '0; m_age = 0;
      end else if (x.stall) begin
        m_age = m_age + 1;
      end else begin
        m_v = x.v; m_rw = x.rw; m_dest = x.dest;
        m_data = x.m2r ? x.ld : x.alu;
        m_age = 0;
      end
    end
  endtask

  task automatic check_model();
    bit w;
    w = m_we();
    chk("reg_we", b32.reg_we, w);
    chk("reg_waddr", b32.reg_waddr, w ? m_dest : 5'd0);
    chk("reg_wdata", b32.reg_wdata, w ? m_data : 32'd0);
    chk("fwd_valid", b32.fwd_valid, w);
    chk("fwd_reg", b32.fwd_reg, w ? m_dest : 5'd0);
    chk("fwd_data", b32.fwd_data, w ? m_data : 32'd0);
    chk("last_we", b32.last_we, m_lwe);
    chk("last_waddr", b32.last_waddr, m_lwa);
    chk("last_wdata", b32.last_wdata, m_lwd);
    chk("retired_count", b32.retired_count, m_cnt);
    chk("retired_count4", b4.retired_count, m_cnt % 16);
    chk("reg_we4", b4.reg_we, w);
  endtask

  task automatic step(input in_t x);
    apply(x);
    @(posedge clk);
    model_edge(x);
    #1;
    check_model();
  endtask

  vec_t tbl[$];
  in_t  idle;

  initial begin
    idle = mi(0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
    // rst v rw m2r st fl dest alu ld | we wa wd | lwe lwa lwd | cnt
    tbl.push_back(mv(mi(1,0,0,0,0,0, 0, 0, 0), 0,0,0, 0,0,0, 0));
    tbl.push_back(mv(mi(0,1,1,0,0,0, 5, 32'h1234, 32'hFFFF_FFFF),
                     1,5,32'h1234, 0,0,0, 0));
    tbl.push_back(mv(mi(0,1,1,1,0,0, 9, 32'h40, 32'hDEAD_BEEF),
                     1,9,32'hDEAD_BEEF, 1,5,32'h1234, 1));
    tbl.push_back(mv(mi(0,1,1,0,0,0, 3, 32'h33, 0),
                     1,3,32'h33, 1,9,32'hDEAD_BEEF, 2));
    tbl.push_back(mv(mi(0,1,1,0,1,0, 7, 32'h77, 0), 0,0,0, 1,3,32'h33, 3));
    tbl.push_back(mv(mi(0,1,1,0,1,0, 7, 32'h77, 0), 0,0,0, 0,0,0, 3));
    tbl.push_back(mv(mi(0,1,1,0,1,0, 7, 32'h77, 0), 0,0,0, 0,0,0, 3));
    tbl.push_back(mv(mi(0,1,1,0,0,0, 7, 32'h77, 0), 1,7,32'h77, 0,0,0, 3));
    tbl.push_back(mv(mi(0,1,1,0,0,1, 8, 32'h88, 0), 0,0,0, 1,7,32'h77, 4));
    tbl.push_back(mv(mi(0,1,1,0,0,0, 10, 32'hA, 0), 1,10,32'hA, 0,0,0, 4));
    tbl.push_back(mv(mi(0,1,1,0,1,1, 11, 32'hB, 0), 0,0,0, 1,10,32'hA, 5));
    tbl.push_back(mv(mi(0,1,1,0,0,0, 0, 32'h55, 0), 0,0,0, 0,0,0, 5));
    tbl.push_back(mv(mi(0,0,0,0,0,0, 0, 0, 0), 0,0,0, 0,0,0, 6));
    tbl.push_back(mv(mi(0,1,1,0,0,0, 12, 32'hC, 0), 1,12,32'hC, 0,0,0, 6));
    tbl.push_back(mv(mi(0,0,0,0,1,0, 0, 0, 0), 0,0,0, 1,12,32'hC, 7));
    tbl.push_back(mv(mi(1,0,0,0,1,0, 0, 0, 0), 0,0,0, 0,0,0, 0));
    tbl.push_back(mv(mi(0,0,0,0,0,0, 0, 0, 0), 0,0,0, 0,0,0, 0));
    tbl.push_back(mv(mi(0,1,0,0,0,0, 4, 32'h4, 0), 0,0,0, 0,0,0, 0));
    tbl.push_back(mv(mi(0,0,0,0,1,0, 0, 0, 0), 0,0,0, 0,0,0, 1));
    tbl.push_back(mv(mi(0,0,0,0,1,0, 0, 0, 0), 0,0,0, 0,0,0, 1));
    tbl.push_back(mv(mi(0,0,0,0,0,0, 0, 0, 0), 0,0,0, 0,0,0, 1));

    foreach (tbl[k]) begin
      step(tbl[k].i);
      chk($sformatf("v%0d.we", k), b32.reg_we, tbl[k].we);
      chk($sformatf("v%0d.wa", k), b32.reg_waddr, tbl[k].wa);
      chk($sformatf("v%0d.wd", k), b32.reg_wdata, tbl[k].wd);
      chk($sformatf("v%0d.fv", k), b32.fwd_valid, tbl[k].we);
      chk($sformatf("v%0d.lwe", k), b32.last_we, tbl[k].lwe);
      chk($sformatf("v%0d.lwa", k), b32.last_waddr, tbl[k].lwa);
      chk($sformatf("v%0d.lwd", k), b32.last_wdata, tbl[k].lwd);
      chk($sformatf("v%0d.cnt", k), b32.retired_count, tbl[k].cnt);
    end

    // 17 back-to-back retirements wrap the 4-bit counter to 1
    step(mi(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int n = 0; n < 17; n++)
      step(mi(0, 1, 1, 0, 0, 0, 5'($urandom_range(0, 31)),
              $urandom, $urandom));
    step(idle);
    chk("wrap4", b4.retired_count, 4'd1);
    chk("wrap32", b32.retired_count, 32'd17);

    for (int n = 0; n < 2000; n++) begin
      in_t x;
      x.rst   = ($urandom_range(0, 99) < 2);
      x.v     = ($urandom_range(0, 99) < 75);
      x.rw    = ($urandom_range(0, 99) < 70);
      x.m2r   = $urandom_range(0, 1);
      x.stall = ($urandom_range(0, 99) < 25);
      x.flush = ($urandom_range(0, 99) < 10);
      x.dest  = ($urandom_range(0, 9) == 0) ? 5'd0
                                            : 5'($urandom_range(0, 31));
      x.alu   = $urandom;
      x.ld    = $urandom;
      step(x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
